// File: rtl/pix_pkg.sv
// ---------------------------------------------------------------------------
// pix_pkg
// Shared definitions for the pixel burst packer: the RGB565 pixel width, the
// 22-bit word address width and the read FSM state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package pix_pkg;

    localparam int PIX_W  = 16;   // RGB565 pixel / memory word width
    localparam int ADDR_W = 22;   // word address width

    typedef logic [PIX_W-1:0]  pixel_t;
    typedef logic [ADDR_W-1:0] addr_t;

    // Read FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_XFER = 2'd2;

endpackage

// File: rtl/pix_burst_packer_if.sv
// ---------------------------------------------------------------------------
// pix_burst_packer_if
// Bundles the camera-side pixel inputs and the burst-side request/pop bus of
// the pixel burst packer.
//   pix_vsync, pix_valid, pix_data : camera frame sync, strobe, RGB565 pixel
//   burst_req, burst_addr          : burst ready + start word address
//   burst_ack, rd_en, rd_data      : request accept, word pop, popped word
//   frame_done, overflow           : end-of-frame pulse, sticky drop flag
// Modports: slave = the packer, master = the camera/memory side driving it.
// ---------------------------------------------------------------------------
interface pix_burst_packer_if;
    import pix_pkg::*;

    logic   pix_vsync;
    logic   pix_valid;
    pixel_t pix_data;
    logic   burst_req;
    addr_t  burst_addr;
    logic   burst_ack;
    logic   rd_en;
    pixel_t rd_data;
    logic   frame_done;
    logic   overflow;

    modport slave (
        input  pix_vsync, pix_valid, pix_data, burst_ack, rd_en,
        output burst_req, burst_addr, rd_data, frame_done, overflow
    );

    modport master (
        output pix_vsync, pix_valid, pix_data, burst_ack, rd_en,
        input  burst_req, burst_addr, rd_data, frame_done, overflow
    );

endinterface

// File: rtl/pix_burst_packer_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with an array store and a registered read port (data is
// valid the cycle after a pop). A write while full is accepted only when a
// pop happens in the same cycle; a pop while empty is ignored.
//   clk, rst         : clock, asynchronous active-high reset
//   flush            : synchronous clear of pointers and fill count
//   wr_en, wr_data   : push request and data
//   rd_en, rd_data   : pop request and registered data
//   full, empty      : status
//   count            : fill level, log2(DEPTH)+1 bits
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic [WIDTH-1:0] rd_data_reg;
    logic             do_wr;
    logic             do_rd;

    assign full  = (count_reg == DEPTH_CNT);
    assign empty = (count_reg == '0);
    assign do_rd = rd_en && !empty;
    // When full, the slot being read this cycle frees room for the write.
    assign do_wr = wr_en && (!full || do_rd);

    // Storage kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (do_wr && !flush) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            rd_data_reg <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_rd) begin
                rd_ptr_reg  <= rd_ptr_reg + AW'(1);
                rd_data_reg <= mem[rd_ptr_reg];
            end
            case ({do_wr, do_rd})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rd_data = rd_data_reg;
    assign count   = count_reg;

endmodule

// File: rtl/pix_burst_packer.sv
// ---------------------------------------------------------------------------
// pix_burst_packer
// Buffers RGB565 camera pixels and hands them to a memory writer in fixed
// bursts of BURST_LEN words at consecutive word addresses starting from
// BASE_ADDR on every frame.
//   sys_clk, sys_rst : clock, asynchronous active-high reset
//   bus (slave)      : pixel inputs, burst request/ack, word pop, rd_data,
//                      frame_done pulse, sticky overflow flag
// ---------------------------------------------------------------------------
module pix_burst_packer
    import pix_pkg::*;
#(
    parameter int          IMG_W      = 640,
    parameter int          IMG_H      = 480,
    parameter int          BURST_LEN  = 64,
    parameter int          FIFO_DEPTH = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 22'h0
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    pix_burst_packer_if.slave bus
);

    localparam int TOTAL  = IMG_W * IMG_H;
    localparam int NBURST = TOTAL / BURST_LEN;
    localparam int PCNT_W = $clog2(TOTAL + 1);
    localparam int BEAT_W = $clog2(BURST_LEN) + 1;
    localparam int BCNT_W = $clog2(NBURST) + 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    localparam logic [PCNT_W-1:0] TOTAL_PIX  = PCNT_W'(TOTAL);
    localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(BURST_LEN - 1);
    localparam logic [BCNT_W-1:0] BURST_LAST = BCNT_W'(NBURST - 1);
    localparam logic [CNT_W-1:0]  BURST_CNT  = CNT_W'(BURST_LEN);
    localparam addr_t             ADDR_STEP  = ADDR_W'(BURST_LEN);

    logic              vsync_reg;
    logic              vsync_prev_reg;
    logic [1:0]        state_reg;
    logic              pending_reg;
    logic              armed_reg;      // a frame start has been applied since reset
    logic              overflow_reg;
    logic              frame_done_reg;
    addr_t             addr_reg;
    logic [PCNT_W-1:0] pix_cnt_reg;
    logic [BEAT_W-1:0] beat_reg;
    logic [BCNT_W-1:0] burst_cnt_reg;

    logic              frame_start;
    logic              apply_start;
    logic              pix_accept;
    logic              push;
    logic              pop;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    pixel_t            fifo_rd_data;

    // Edge taken between two registered copies, so it acts one cycle late.
    assign frame_start = vsync_reg && !vsync_prev_reg;
    // A frame start (fresh or held pending) is only acted on in IDLE.
    assign apply_start = (state_reg == ST_IDLE) && (frame_start || pending_reg);

    // Pixels count against the frame until IMG_W*IMG_H are seen, dropped or not.
    assign pix_accept = bus.pix_valid && armed_reg && (pix_cnt_reg != TOTAL_PIX)
                        && !apply_start;
    assign pop  = bus.rd_en && (state_reg == ST_XFER) && !fifo_empty;
    assign push = pix_accept && (!fifo_full || pop);
    assign drop = pix_accept && fifo_full && !pop;

    sync_fifo #(
        .WIDTH (PIX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .flush   (apply_start),
        .wr_en   (push),
        .wr_data (bus.pix_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            vsync_reg      <= 1'b0;
            vsync_prev_reg <= 1'b0;
            state_reg      <= ST_IDLE;
            pending_reg    <= 1'b0;
            armed_reg      <= 1'b0;
            overflow_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
            addr_reg       <= BASE_ADDR;
            pix_cnt_reg    <= '0;
            beat_reg       <= '0;
            burst_cnt_reg  <= '0;
        end else begin
            vsync_reg      <= bus.pix_vsync;
            vsync_prev_reg <= vsync_reg;
            frame_done_reg <= 1'b0;

            if (pix_accept) begin
                pix_cnt_reg <= pix_cnt_reg + PCNT_W'(1);
            end
            if (drop) begin
                overflow_reg <= 1'b1;
            end
            // Includes the last beat of XFER: the flag is then applied in IDLE.
            if (frame_start && (state_reg != ST_IDLE)) begin
                pending_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (apply_start) begin
                        pending_reg   <= 1'b0;
                        armed_reg     <= 1'b1;
                        overflow_reg  <= 1'b0;
                        addr_reg      <= BASE_ADDR;
                        pix_cnt_reg   <= '0;
                        burst_cnt_reg <= '0;
                    end else if (fifo_count >= BURST_CNT) begin
                        state_reg <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.burst_ack) begin
                        state_reg <= ST_XFER;
                        beat_reg  <= '0;
                    end
                end
                ST_XFER: begin
                    if (pop) begin
                        beat_reg <= beat_reg + BEAT_W'(1);
                        if (beat_reg == BEAT_LAST) begin
                            state_reg     <= ST_IDLE;
                            addr_reg      <= addr_reg + ADDR_STEP;
                            burst_cnt_reg <= burst_cnt_reg + BCNT_W'(1);
                            // The frame's last burst carries pixel IMG_W*IMG_H.
                            if (burst_cnt_reg == BURST_LAST) begin
                                frame_done_reg <= 1'b1;
                            end
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.burst_req  = (state_reg == ST_REQ);
    assign bus.burst_addr = addr_reg;
    assign bus.rd_data    = fifo_rd_data;
    assign bus.frame_done = frame_done_reg;
    assign bus.overflow   = overflow_reg;

endmodule

// File: tb/tb_pix_burst_packer.sv
// ---------------------------------------------------------------------------
// tb_pix_burst_packer
// Scoreboard bench for pix_burst_packer with IMG_W=8, IMG_H=2, BURST_LEN=4,
// FIFO_DEPTH=8, BASE_ADDR=0x100. Scenarios queue the hand-computed burst
// addresses and words; a monitor compares them as the DUT presents them.
// ---------------------------------------------------------------------------
module tb_pix_burst_packer;

    localparam int          BL   = 4;
    localparam logic [21:0] BASE = 22'h100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pix_burst_packer_if bus_if ();

    pix_burst_packer #(
        .IMG_W      (8),
        .IMG_H      (2),
        .BURST_LEN  (BL),
        .FIFO_DEPTH (8),
        .BASE_ADDR  (BASE)
    ) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bus_if)
    );

    int          checks = 0;
    int          errors = 0;
    int          frame_done_cnt = 0;
    bit          pop_expected = 1'b0;
    logic [15:0] exp_data_q[$];
    logic [21:0] exp_addr_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_burst(input logic [21:0] addr, input logic [15:0] first);
        exp_addr_q.push_back(addr);
        for (int i = 0; i < BL; i++) begin
            exp_data_q.push_back(first + 16'(i));
        end
    endtask

    task automatic push_pix(input logic [15:0] d);
        bus_if.pix_valid = 1'b1;
        bus_if.pix_data  = d;
        tick();
        bus_if.pix_valid = 1'b0;
    endtask

    task automatic vsync_pulse();
        bus_if.pix_vsync = 1'b1;
        tick();
        bus_if.pix_vsync = 1'b0;
        repeat (4) tick();
    endtask

    // Waits for burst_req, acks it, then pops BL words on consecutive cycles.
    // Optionally pulses vsync during XFER and/or pushes a pixel on the first pop.
    task automatic serve_burst(input bit vs_mid, input bit push_en, input logic [15:0] push_val);
        int t;
        t = 0;
        while (!bus_if.burst_req && t < 100) begin
            tick();
            t++;
        end
        if (!bus_if.burst_req) begin
            checks++;
            errors++;
            $display("FAIL burst_req_wait: got 0 after 100 cycles, expected 1");
            return;
        end
        bus_if.burst_ack = 1'b1;
        tick();
        bus_if.burst_ack = 1'b0;
        bus_if.rd_en     = 1'b1;
        pop_expected     = 1'b1;
        if (vs_mid)  bus_if.pix_vsync = 1'b1;
        if (push_en) begin
            bus_if.pix_valid = 1'b1;
            bus_if.pix_data  = push_val;
        end
        tick();
        bus_if.pix_vsync = 1'b0;
        if (push_en) bus_if.pix_valid = 1'b0;
        repeat (BL - 1) tick();
        bus_if.rd_en = 1'b0;
        pop_expected = 1'b0;
    endtask

    // Scoreboard monitor: sampled on the falling edge, away from DUT updates.
    initial begin : monitor
        logic        data_due;
        logic [15:0] exp_d;
        logic [21:0] exp_a;
        data_due = 1'b0;
        forever begin
            @(negedge clk);
            if (data_due) begin
                checks++;
                if (exp_data_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_data_unexpected: got 0x%04h, expected no word", bus_if.rd_data);
                end else begin
                    exp_d = exp_data_q.pop_front();
                    if (bus_if.rd_data !== exp_d) begin
                        errors++;
                        $display("FAIL rd_data: got 0x%04h, expected 0x%04h", bus_if.rd_data, exp_d);
                    end else begin
                        $display("ok   rd_data: 0x%04h", bus_if.rd_data);
                    end
                end
            end
            data_due = bus_if.rd_en && pop_expected;
            if (bus_if.burst_req && bus_if.burst_ack) begin
                checks++;
                if (exp_addr_q.size() == 0) begin
                    errors++;
                    $display("FAIL burst_addr_unexpected: got 0x%06h, expected no burst", bus_if.burst_addr);
                end else begin
                    exp_a = exp_addr_q.pop_front();
                    if (bus_if.burst_addr !== exp_a) begin
                        errors++;
                        $display("FAIL burst_addr: got 0x%06h, expected 0x%06h", bus_if.burst_addr, exp_a);
                    end else begin
                        $display("ok   burst_addr: 0x%06h", bus_if.burst_addr);
                    end
                end
            end
            if (bus_if.frame_done) begin
                frame_done_cnt++;
                $display("info frame_done pulse %0d", frame_done_cnt);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish by 200000, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        bit saw_req;
        bus_if.pix_vsync = 1'b0;
        bus_if.pix_valid = 1'b0;
        bus_if.pix_data  = '0;
        bus_if.burst_ack = 1'b0;
        bus_if.rd_en     = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("reset_burst_req",  32'(bus_if.burst_req),  32'h0);
        check("reset_burst_addr", 32'(bus_if.burst_addr), 32'h100);
        check("reset_rd_data",    32'(bus_if.rd_data),    32'h0);
        check("reset_frame_done", 32'(bus_if.frame_done), 32'h0);
        check("reset_overflow",   32'(bus_if.overflow),   32'h0);

        // A: full frame of 16 pixels, bursts serviced alongside the pixel stream
        vsync_pulse();
        for (int b = 0; b < 4; b++) expect_burst(BASE + 22'(4 * b), 16'(4 * b));
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    push_pix(16'(i));
                    tick();
                end
            end
            begin
                for (int b = 0; b < 4; b++) serve_burst(1'b0, 1'b0, 16'h0);
            end
        join
        repeat (5) tick();
        check("A_frame_done_cnt", 32'(frame_done_cnt), 32'd1);
        check("A_overflow",       32'(bus_if.overflow), 32'h0);
        check("A_data_left",      32'(exp_data_q.size()), 32'd0);

        // B: 9 pixels with no ack -> 9th dropped; vsync outside IDLE held pending
        vsync_pulse();
        for (int i = 0; i < 9; i++) push_pix(16'h20 + 16'(i));
        check("B_burst_req",  32'(bus_if.burst_req),  32'h1);
        check("B_burst_addr", 32'(bus_if.burst_addr), 32'h100);
        check("B_overflow",   32'(bus_if.overflow),   32'h1);
        repeat (10) tick();
        check("B_burst_req_held", 32'(bus_if.burst_req), 32'h1);
        vsync_pulse();
        expect_burst(BASE, 16'h20);
        serve_burst(1'b0, 1'b0, 16'h0);
        repeat (5) tick();
        check("B_overflow_cleared", 32'(bus_if.overflow),   32'h0);
        check("B_addr_restored",    32'(bus_if.burst_addr), 32'h100);
        check("B_flushed_no_req",   32'(bus_if.burst_req),  32'h0);

        // C: vsync during XFER of the burst at 0x104
        for (int i = 0; i < 8; i++) push_pix(16'h30 + 16'(i));
        expect_burst(BASE, 16'h30);
        serve_burst(1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 4; i++) push_pix(16'h38 + 16'(i));
        expect_burst(BASE + 22'd4, 16'h34);
        serve_burst(1'b1, 1'b0, 16'h0);
        repeat (6) tick();
        check("C_flushed_no_req", 32'(bus_if.burst_req),  32'h0);
        check("C_addr_restored",  32'(bus_if.burst_addr), 32'h100);
        for (int i = 0; i < 4; i++) push_pix(16'h40 + 16'(i));
        expect_burst(BASE, 16'h40);
        serve_burst(1'b0, 1'b0, 16'h0);

        // D: FIFO full, push and pop in the same cycle; then finish the frame
        for (int i = 0; i < 8; i++) push_pix(16'h50 + 16'(i));
        expect_burst(BASE + 22'd4, 16'h50);
        serve_burst(1'b0, 1'b1, 16'h58);
        check("D_overflow", 32'(bus_if.overflow), 32'h0);
        expect_burst(BASE + 22'd8, 16'h54);
        serve_burst(1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 3; i++) push_pix(16'h59 + 16'(i));
        expect_burst(BASE + 22'd12, 16'h58);
        serve_burst(1'b0, 1'b0, 16'h0);
        repeat (4) tick();
        check("D_overflow_end",   32'(bus_if.overflow), 32'h0);
        check("D_frame_done_cnt", 32'(frame_done_cnt),  32'd2);

        // E: rd_en in IDLE and in REQ must not pop
        vsync_pulse();
        for (int i = 0; i < 3; i++) push_pix(16'h60 + 16'(i));
        bus_if.rd_en = 1'b1;
        repeat (3) tick();
        bus_if.rd_en = 1'b0;
        tick();
        check("E_idle_rd_data",   32'(bus_if.rd_data),   32'h5B);
        check("E_idle_burst_req", 32'(bus_if.burst_req), 32'h0);
        push_pix(16'h63);
        tick();
        bus_if.rd_en = 1'b1;
        repeat (3) tick();
        bus_if.rd_en = 1'b0;
        tick();
        check("E_req_rd_data",   32'(bus_if.rd_data),   32'h5B);
        check("E_req_burst_req", 32'(bus_if.burst_req), 32'h1);
        expect_burst(BASE, 16'h60);
        serve_burst(1'b0, 1'b0, 16'h0);

        // F: reset mid-XFER
        for (int i = 0; i < 4; i++) push_pix(16'h64 + 16'(i));
        exp_addr_q.push_back(BASE + 22'd4);
        exp_data_q.push_back(16'h64);
        exp_data_q.push_back(16'h65);
        while (!bus_if.burst_req) tick();
        bus_if.burst_ack = 1'b1;
        tick();
        bus_if.burst_ack = 1'b0;
        bus_if.rd_en     = 1'b1;
        pop_expected     = 1'b1;
        repeat (2) tick();
        bus_if.rd_en = 1'b0;
        pop_expected = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("F_rst_burst_req",  32'(bus_if.burst_req),  32'h0);
        check("F_rst_burst_addr", 32'(bus_if.burst_addr), 32'h100);
        check("F_rst_rd_data",    32'(bus_if.rd_data),    32'h0);
        check("F_rst_frame_done", 32'(bus_if.frame_done), 32'h0);
        check("F_rst_overflow",   32'(bus_if.overflow),   32'h0);
        repeat (2) tick();
        rst = 1'b0;
        saw_req = 1'b0;
        for (int i = 0; i < 30; i++) begin
            bus_if.pix_valid = (i < 6);
            bus_if.pix_data  = 16'h70 + 16'(i);
            tick();
            if (bus_if.burst_req) saw_req = 1'b1;
        end
        bus_if.pix_valid = 1'b0;
        check("F_no_req_after_rst", 32'(saw_req), 32'h0);

        check("end_addr_queue_empty", 32'(exp_addr_q.size()), 32'd0);
        check("end_data_queue_empty", 32'(exp_data_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pix_burst_packer.md
PIX_BURST_PACKER -- requirements
Module: pix_burst_packer

Interface
REQ-001 Parameter IMG_W, default 640, active pixels per line.
REQ-002 Parameter IMG_H, default 480, active lines per frame.
REQ-003 Parameter BURST_LEN, default 64, 16-bit words per write burst; power of two; IMG_W*IMG_H SHALL be a multiple of it.
REQ-004 Parameter FIFO_DEPTH, default 256, pixel buffer depth; power of two, at least 2*BURST_LEN.
REQ-005 Parameter BASE_ADDR, default 22'h0, word address of the first burst of every frame.
REQ-006 sys_clk  in  1  single clock; camera pixel domain; all logic on its rising edge.
REQ-007 sys_rst  in  1  asynchronous, active-high reset.
REQ-008 pix_vsync  in  1  camera frame sync; active high.
REQ-009 pix_valid  in  1  pixel strobe from the camera data stage.
REQ-010 pix_data  in  16  RGB565 pixel.
REQ-011 burst_req  out  1  a full burst is buffered and ready.
REQ-012 burst_addr  out  22  burst start word address; stable while burst_req is high.
REQ-013 burst_ack  in  1  downstream accepts the request.
REQ-014 rd_en  in  1  downstream pops one word.
REQ-015 rd_data  out  16  popped word.
REQ-016 frame_done  out  1  one-cycle pulse at the end of a frame.
REQ-017 overflow  out  1  sticky flag: a pixel was dropped.

Function
REQ-018 A rising edge of pix_vsync is detected from a registered copy, so frame start takes effect one cycle after the edge.
REQ-019 On frame start in IDLE: the FIFO is flushed, the address is set to BASE_ADDR, the pixel counter is cleared, and overflow is cleared.
REQ-020 A frame start outside IDLE sets a pending flag; that flag is applied on the next entry to IDLE.
REQ-021 Push: when pix_valid is high and the FIFO is not full, pix_data is written and the pixel counter is incremented.
REQ-022 Pixels beyond IMG_W*IMG_H are ignored until the next frame start.
REQ-023 A pix_valid while the FIFO is full drops the pixel and sets overflow; the pixel counter still increments.
REQ-024 Push and pop in the same cycle while full are both performed; the fill count is unchanged and overflow is not set.
REQ-025 Read FSM state IDLE: move to REQ when fill count >= BURST_LEN and no frame start is pending.
REQ-026 Read FSM state REQ: burst_req is high; on burst_ack, move to XFER and deassert burst_req the next cycle.
REQ-027 Read FSM state XFER: each rd_en with the FIFO non-empty pops one word, and rd_data is valid the cycle after rd_en.
REQ-028 In XFER, after BURST_LEN pops the address advances by BURST_LEN and the FSM returns to IDLE.
REQ-029 rd_en is ignored outside XFER or when the FIFO is empty; no pointer moves.
REQ-030 The address wraps modulo 2^22.
REQ-031 frame_done pulses one cycle after the burst completes that accounts for pixel IMG_W*IMG_H of the current frame.
REQ-032 The fill count is log2(FIFO_DEPTH)+1 bits wide, and pointers wrap at FIFO_DEPTH.

Reset
REQ-033 On sys_rst, the FSM goes to IDLE and the pointers, fill count, pixel counter and pending flag are set to zero.
REQ-034 On sys_rst, the address is set to BASE_ADDR and burst_req, frame_done, overflow and rd_data are set to 0.
REQ-035 Reset asserted mid-burst aborts the burst with no further output activity; after release the block waits for a frame start.

Structure
REQ-036 A shared package pix_pkg holds the FSM state encoding, the RGB565 pixel width constant and the address width constant (22).
REQ-037 Storage is one sub-module, sync_fifo, parameterised by width and depth: single clock, 1-cycle read latency, with full, empty and count outputs.

Verification
All scenarios use IMG_W=8, IMG_H=2, BURST_LEN=4, FIFO_DEPTH=8, BASE_ADDR=0x100.
REQ-038 Scenario: vsync pulse, then 16 contiguous pixels 0..15, with ack and rd_en bursts.
  Required: four bursts at 0x100, 0x104, 0x108, 0x10C; data in order; frame_done pulses once.
REQ-039 Scenario: 9 pixels pushed with no burst_ack.
  Required: burst_req stays high; the 9th pixel is dropped; overflow=1.
  The next vsync in IDLE clears overflow and restores the address to 0x100.
REQ-040 Scenario: vsync edge during XFER of the burst at 0x104.
  Required: the burst completes its 4 words; then the FIFO is flushed and the next burst_addr is 0x100.
REQ-041 Scenario: FIFO full with a simultaneous push and pop.
  Required: count stays 8; overflow stays 0; the popped word matches the oldest pixel.
REQ-042 Scenario: rd_en in IDLE and REQ.
  Required: no pop; the count is unchanged.
REQ-043 Scenario: sys_rst pulsed mid-XFER.
  Required: all outputs are 0 immediately; with no vsync after release, no burst_req appears.
